hilo_muldiv: RTL and testbench

//  Execute-stage multiply/divide unit owning the HI/LO register pair. Consumes the 8-bit

---
 rtl/hilo_muldiv_pkg.sv | 21 ++
 rtl/hilo_muldiv_if.sv | 33 +++
 rtl/hilo_muldiv_div_radix2.sv | 76 +++++++
 rtl/hilo_muldiv.sv | 148 ++++++++++++++
 tb/tb_hilo_muldiv.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/hilo_muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit.
//   ALU op codes consumed from the decoder (8-bit alucontrol field)
//   FSM state encoding for the divide sequencer
package hilo_muldiv_pkg;

   localparam int unsigned ALU_OP_W = 8;

   // Decoder op codes for the ops this unit acts on, plus ADD as a non-muldiv example.
   localparam logic [ALU_OP_W-1:0] EXE_MULT_OP  = 8'b0001_1000;
   localparam logic [ALU_OP_W-1:0] EXE_MULTU_OP = 8'b0001_1001;
   localparam logic [ALU_OP_W-1:0] EXE_DIV_OP   = 8'b0001_1010;
   localparam logic [ALU_OP_W-1:0] EXE_DIVU_OP  = 8'b0001_1011;
   localparam logic [ALU_OP_W-1:0] EXE_ADD_OP   = 8'b0010_0000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DIV  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/hilo_muldiv_if.sv
// Execute-stage bundle between the pipeline and the HI/LO multiply/divide unit.
//   master : pipeline side (drives op, operands, MTHI/MTLO, flush)
//   slave  : hilo_muldiv side (returns HI/LO, stall, busy)
interface hilo_muldiv_if
   import hilo_muldiv_pkg::*;
#(
   parameter int unsigned WIDTH = 32
);

   logic [ALU_OP_W-1:0] alucontrol;
   logic                en_i;
   logic                flush_i;
   logic [WIDTH-1:0]    a_i;
   logic [WIDTH-1:0]    b_i;
   logic                hi_we_i;
   logic                lo_we_i;
   logic [WIDTH-1:0]    mt_data_i;
   logic [WIDTH-1:0]    hi_o;
   logic [WIDTH-1:0]    lo_o;
   logic                stall_o;
   logic                busy_o;

   modport master (
      output alucontrol, en_i, flush_i, a_i, b_i, hi_we_i, lo_we_i, mt_data_i,
      input  hi_o, lo_o, stall_o, busy_o
   );

   modport slave (
      input  alucontrol, en_i, flush_i, a_i, b_i, hi_we_i, lo_we_i, mt_data_i,
      output hi_o, lo_o, stall_o, busy_o
   );

endinterface

// File: rtl/hilo_muldiv_div_radix2.sv
// Iterative unsigned radix-2 restoring divider core, one quotient bit per clock.
//   clk, resetn   clock, async active-low reset
//   start_i       load operands and begin WIDTH iterations
//   abort_i       cancel a running divide (wins over start_i)
//   dividend_i    unsigned dividend
//   divisor_i     unsigned divisor (zero gives all-ones quotient, remainder = dividend)
//   quot_o/rem_o  result, valid from the cycle after last_o until the next start
//   last_o        combinational: the current edge completes the final iteration
module hilo_muldiv_div_radix2 #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             start_i,
   input  logic             abort_i,
   input  logic [WIDTH-1:0] dividend_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic [WIDTH-1:0] quot_o,
   output logic [WIDTH-1:0] rem_o,
   output logic             last_o
);

   localparam int unsigned          CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(WIDTH - 1);

   logic             run_q;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] quot_q;
   logic [WIDTH-1:0] rem_q;
   logic [WIDTH-1:0] dvsr_q;

   logic [WIDTH:0]   part_c;
   logic [WIDTH:0]   diff_c;
   logic             fit_c;

   // Trial subtraction: shift the next dividend bit into the partial remainder.
   always_comb begin
      part_c = {rem_q, quot_q[WIDTH-1]};
      diff_c = part_c - {1'b0, dvsr_q};
      fit_c  = ~diff_c[WIDTH];
   end

   assign last_o = run_q & (cnt_q == CNT_LAST);
   assign quot_o = quot_q;
   assign rem_o  = rem_q;

   // Quotient bits are shifted into the vacated low end of the dividend register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         run_q  <= 1'b0;
         cnt_q  <= '0;
         quot_q <= '0;
         rem_q  <= '0;
         dvsr_q <= '0;
      end else if (abort_i) begin
         run_q <= 1'b0;
         cnt_q <= '0;
      end else if (start_i) begin
         run_q  <= 1'b1;
         cnt_q  <= '0;
         quot_q <= dividend_i;
         rem_q  <= '0;
         dvsr_q <= divisor_i;
      end else if (run_q) begin
         rem_q  <= fit_c ? diff_c[WIDTH-1:0] : part_c[WIDTH-1:0];
         quot_q <= {quot_q[WIDTH-2:0], fit_c};
         if (last_o) begin
            run_q <= 1'b0;
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/hilo_muldiv.sv
// Execute-stage multiply/divide unit owning the HI/LO register pair.
//   clk, resetn  clock, async active-low reset
//   bus (slave)  alucontrol, en_i, flush_i, a_i, b_i, hi_we_i, lo_we_i, mt_data_i in;
//                hi_o, lo_o (registered), stall_o (combinational), busy_o out
// MULT/MULTU write {HI,LO} at the accept edge. DIV/DIVU run WIDTH iterations in the
// divider core, then one DONE cycle writes LO=quotient, HI=remainder.
module hilo_muldiv
   import hilo_muldiv_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic          clk,
   input  logic          resetn,
   hilo_muldiv_if.slave  bus
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             q_neg_q;
   logic             r_neg_q;
   logic             dz_q;

   logic             is_mult_c, is_multu_c, is_div_c, is_divu_c;
   logic             go_c, mul_go_c, div_go_c;
   logic             a_neg_c, b_neg_c;
   logic [WIDTH-1:0] a_abs_c, b_abs_c;
   logic [2*WIDTH-1:0] a_ext_c, b_ext_c, prod_c;
   logic [WIDTH-1:0] quot_c, rem_c;
   logic [WIDTH-1:0] q_fix_c, r_fix_c;
   logic             last_c;
   logic             stall_c;
   logic             abort_c;

   // Op decode and accept condition.
   assign is_mult_c  = (bus.alucontrol == EXE_MULT_OP);
   assign is_multu_c = (bus.alucontrol == EXE_MULTU_OP);
   assign is_div_c   = (bus.alucontrol == EXE_DIV_OP);
   assign is_divu_c  = (bus.alucontrol == EXE_DIVU_OP);
   assign go_c       = bus.en_i & ~bus.flush_i & (state_q == ST_IDLE);
   assign mul_go_c   = go_c & (is_mult_c | is_multu_c);
   assign div_go_c   = go_c & (is_div_c | is_divu_c);

   // Sign-extend to 2W so one unsigned multiplier yields both signed and unsigned products.
   assign a_ext_c = {{WIDTH{is_mult_c & bus.a_i[WIDTH-1]}}, bus.a_i};
   assign b_ext_c = {{WIDTH{is_mult_c & bus.b_i[WIDTH-1]}}, bus.b_i};
   assign prod_c  = a_ext_c * b_ext_c;

   // Magnitudes handed to the unsigned core; 0x80000000 stays 0x80000000 as unsigned.
   assign a_neg_c = is_div_c & bus.a_i[WIDTH-1];
   assign b_neg_c = is_div_c & bus.b_i[WIDTH-1];
   assign a_abs_c = a_neg_c ? (WIDTH'(0) - bus.a_i) : bus.a_i;
   assign b_abs_c = b_neg_c ? (WIDTH'(0) - bus.b_i) : bus.b_i;

   hilo_muldiv_div_radix2 #(
      .WIDTH (WIDTH)
   ) u_div (
      .clk        (clk),
      .resetn     (resetn),
      .start_i    (div_go_c),
      .abort_i    (abort_c),
      .dividend_i (a_abs_c),
      .divisor_i  (b_abs_c),
      .quot_o     (quot_c),
      .rem_o      (rem_c),
      .last_o     (last_c)
   );

   // Sign fixup. A zero divisor forces an all-ones quotient; the remainder is then |a|
   // re-signed, which restores the dividend exactly as issued.
   assign q_fix_c = dz_q ? '1 : (q_neg_q ? (WIDTH'(0) - quot_c) : quot_c);
   assign r_fix_c = r_neg_q ? (WIDTH'(0) - rem_c) : rem_c;

   // Next-state, HI/LO update, stall and abort.
   always_comb begin
      state_d = state_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      stall_c = 1'b0;
      abort_c = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (mul_go_c) begin
               {hi_d, lo_d} = prod_c;
            end else if (go_c) begin
               if (bus.hi_we_i) hi_d = bus.mt_data_i;
               if (bus.lo_we_i) lo_d = bus.mt_data_i;
            end
            if (div_go_c) begin
               state_d = ST_DIV;
               stall_c = 1'b1;
            end
         end
         ST_DIV: begin
            if (bus.flush_i) begin
               state_d = ST_IDLE;
               abort_c = 1'b1;
            end else begin
               stall_c = 1'b1;
               if (last_c) state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            // Stall is already low so the divide leaves EX on this same edge.
            state_d = ST_IDLE;
            if (bus.flush_i) begin
               abort_c = 1'b1;
            end else begin
               lo_d = q_fix_c;
               hi_d = r_fix_c;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and HI/LO registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   // Result sign flags captured with the operands.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         q_neg_q <= 1'b0;
         r_neg_q <= 1'b0;
         dz_q    <= 1'b0;
      end else if (div_go_c) begin
         q_neg_q <= a_neg_c ^ b_neg_c;
         r_neg_q <= a_neg_c;
         dz_q    <= (bus.b_i == '0);
      end
   end

   assign bus.hi_o    = hi_q;
   assign bus.lo_o    = lo_q;
   assign bus.stall_o = stall_c;
   assign bus.busy_o  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_hilo_muldiv.sv
// Bench for hilo_muldiv: table of single-cycle ops (MULT/MULTU/MTHI/MTLO), table of
// divides with stall-length checks, and hand sequences for flush and mid-divide reset.
module tb_hilo_muldiv;
   import hilo_muldiv_pkg::*;

   logic clk = 1'b0;
   logic resetn;
   always #5 clk = ~clk;

   hilo_muldiv_if #(.WIDTH(32)) bus ();

   hilo_muldiv #(.WIDTH(32)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   typedef struct {
      logic [7:0]  op;
      logic        en;
      logic        flush;
      logic        hi_we;
      logic        lo_we;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] mt;
      logic [31:0] eh;
      logic [31:0] el;
   } mvec_t;

   typedef struct {
      logic [7:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] eh;
      logic [31:0] el;
   } dvec_t;

   int total = 0;
   int bad   = 0;

   mvec_t mv[14];
   dvec_t dv[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [7:0] op, input logic en, input logic flush,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic hi_we, input logic lo_we, input logic [31:0] mt);
      bus.alucontrol = op;
      bus.en_i       = en;
      bus.flush_i    = flush;
      bus.a_i        = a;
      bus.b_i        = b;
      bus.hi_we_i    = hi_we;
      bus.lo_we_i    = lo_we;
      bus.mt_data_i  = mt;
   endtask

   function automatic mvec_t mk(input logic [7:0] op, input logic en, input logic flush,
                                input logic hi_we, input logic lo_we,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] mt, input logic [31:0] eh,
                                input logic [31:0] el);
      mvec_t v;
      v.op = op; v.en = en; v.flush = flush; v.hi_we = hi_we; v.lo_we = lo_we;
      v.a = a; v.b = b; v.mt = mt; v.eh = eh; v.el = el;
      return v;
   endfunction

   function automatic dvec_t mkd(input logic [7:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] eh,
                                 input logic [31:0] el);
      dvec_t v;
      v.op = op; v.a = a; v.b = b; v.eh = eh; v.el = el;
      return v;
   endfunction

   // Issue a divide, hold it in EX while stalled, then check latency and result.
   task automatic run_div(input string name, input dvec_t d);
      int n;
      n = 0;
      drive(d.op, 1'b1, 1'b0, d.a, d.b, 1'b0, 1'b0, 32'h0);
      #1;
      while (bus.stall_o && n < 40) begin
         n++;
         tick();
      end
      chk({name, "_stall_cycles"}, 32'(n), 32'd33);
      chk({name, "_done_busy"}, 32'(bus.busy_o), 32'd1);
      tick();
      drive(EXE_ADD_OP, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
      #1;
      chk({name, "_hi"}, bus.hi_o, d.eh);
      chk({name, "_lo"}, bus.lo_o, d.el);
      chk({name, "_busy"}, 32'(bus.busy_o), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      //            op            en fl hw lw a             b             mt            exp hi        exp lo
      mv[0]  = mk(EXE_MULT_OP,  1, 0, 0, 0, 32'hFFFFFFFE, 32'h00000003, 32'h0,        32'hFFFFFFFF, 32'hFFFFFFFA);
      mv[1]  = mk(EXE_MULTU_OP, 1, 0, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        32'hFFFFFFFE, 32'h00000001);
      mv[2]  = mk(EXE_MULT_OP,  1, 0, 0, 0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h0,        32'h3FFFFFFF, 32'h00000001);
      mv[3]  = mk(EXE_MULT_OP,  1, 0, 0, 0, 32'h80000000, 32'h80000000, 32'h0,        32'h40000000, 32'h00000000);
      mv[4]  = mk(EXE_MULTU_OP, 1, 0, 0, 0, 32'h00010000, 32'h00010000, 32'h0,        32'h00000001, 32'h00000000);
      mv[5]  = mk(EXE_MULT_OP,  0, 0, 0, 0, 32'h00000005, 32'h00000005, 32'h0,        32'h00000001, 32'h00000000);
      mv[6]  = mk(EXE_MULT_OP,  1, 1, 0, 0, 32'h00000005, 32'h00000005, 32'h0,        32'h00000001, 32'h00000000);
      mv[7]  = mk(EXE_ADD_OP,   1, 0, 0, 1, 32'h00000011, 32'h00000022, 32'h00001234, 32'h00000001, 32'h00001234);
      mv[8]  = mk(EXE_ADD_OP,   1, 0, 1, 0, 32'h00000011, 32'h00000022, 32'h0000DEAD, 32'h0000DEAD, 32'h00001234);
      mv[9]  = mk(EXE_ADD_OP,   1, 0, 0, 0, 32'h00000011, 32'h00000022, 32'h00009999, 32'h0000DEAD, 32'h00001234);
      mv[10] = mk(EXE_ADD_OP,   0, 0, 1, 1, 32'h00000000, 32'h00000000, 32'h0000FFFF, 32'h0000DEAD, 32'h00001234);
      mv[11] = mk(EXE_MULT_OP,  1, 0, 0, 1, 32'h00000002, 32'h00000003, 32'h00005555, 32'h00000000, 32'h00000006);
      mv[12] = mk(EXE_DIV_OP,   0, 0, 0, 0, 32'h00000005, 32'h00000001, 32'h0,        32'h00000000, 32'h00000006);
      mv[13] = mk(EXE_ADD_OP,   1, 1, 1, 0, 32'h00000000, 32'h00000000, 32'h00000077, 32'h00000000, 32'h00000006);

      //             op            a             b             exp hi        exp lo
      dv[0] = mkd(EXE_DIV_OP,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD);
      dv[1] = mkd(EXE_DIV_OP,  32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
      dv[2] = mkd(EXE_DIVU_OP, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF);
      dv[3] = mkd(EXE_DIV_OP,  32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF);
      dv[4] = mkd(EXE_DIV_OP,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
      dv[5] = mkd(EXE_DIVU_OP, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF);
      dv[6] = mkd(EXE_DIVU_OP, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E);

      // Reset state
      resetn = 1'b0;
      drive(EXE_ADD_OP, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
      #12;
      chk("rst_hi", bus.hi_o, 32'h0);
      chk("rst_lo", bus.lo_o, 32'h0);
      chk("rst_busy", 32'(bus.busy_o), 32'd0);
      chk("rst_stall", 32'(bus.stall_o), 32'd0);
      @(negedge clk);
      resetn = 1'b1;
      tick();

      // Single-cycle ops: result visible right after the accept edge, never stalls
      for (int i = 0; i < 14; i++) begin
         drive(mv[i].op, mv[i].en, mv[i].flush, mv[i].a, mv[i].b,
               mv[i].hi_we, mv[i].lo_we, mv[i].mt);
         #1;
         chk($sformatf("m%0d_stall", i), 32'(bus.stall_o), 32'd0);
         tick();
         chk($sformatf("m%0d_hi", i), bus.hi_o, mv[i].eh);
         chk($sformatf("m%0d_lo", i), bus.lo_o, mv[i].el);
         chk($sformatf("m%0d_busy", i), 32'(bus.busy_o), 32'd0);
      end
      drive(EXE_ADD_OP, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
      tick();

      // Divides
      for (int i = 0; i < 7; i++) begin
         run_div($sformatf("d%0d", i), dv[i]);
      end

      // Flush at iteration 10: HI/LO keep 2/14 from the last divide
      drive(EXE_DIVU_OP, 1'b1, 1'b0, 32'd1000, 32'd3, 1'b0, 1'b0, 32'h0);
      #1;
      chk("fl_go_stall", 32'(bus.stall_o), 32'd1);
      tick();
      repeat (10) tick();
      chk("fl_mid_busy", 32'(bus.busy_o), 32'd1);
      chk("fl_mid_stall", 32'(bus.stall_o), 32'd1);
      bus.flush_i = 1'b1;
      #1;
      chk("fl_stall_drop", 32'(bus.stall_o), 32'd0);
      tick();
      drive(EXE_ADD_OP, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
      #1;
      chk("fl_busy", 32'(bus.busy_o), 32'd0);
      chk("fl_stall", 32'(bus.stall_o), 32'd0);
      repeat (3) tick();
      chk("fl_hi", bus.hi_o, 32'h00000002);
      chk("fl_lo", bus.lo_o, 32'h0000000E);

      // Flush landing on the DONE cycle suppresses the write
      drive(EXE_DIV_OP, 1'b1, 1'b0, 32'hFFFFFFF9, 32'h00000002, 1'b0, 1'b0, 32'h0);
      begin
         int n;
         n = 0;
         #1;
         while (bus.stall_o && n < 40) begin
            n++;
            tick();
         end
         chk("fd_stall_cycles", 32'(n), 32'd33);
      end
      bus.flush_i = 1'b1;
      #1;
      chk("fd_stall", 32'(bus.stall_o), 32'd0);
      tick();
      drive(EXE_ADD_OP, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
      #1;
      chk("fd_busy", 32'(bus.busy_o), 32'd0);
      chk("fd_hi", bus.hi_o, 32'h00000002);
      chk("fd_lo", bus.lo_o, 32'h0000000E);

      // Reset pulse mid-divide clears HI/LO and returns to IDLE
      drive(EXE_DIVU_OP, 1'b1, 1'b0, 32'd100, 32'd7, 1'b0, 1'b0, 32'h0);
      tick();
      repeat (5) tick();
      chk("rd_busy_before", 32'(bus.busy_o), 32'd1);
      drive(EXE_ADD_OP, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
      resetn = 1'b0;
      #1;
      chk("rd_hi", bus.hi_o, 32'h0);
      chk("rd_lo", bus.lo_o, 32'h0);
      chk("rd_busy", 32'(bus.busy_o), 32'd0);
      chk("rd_stall", 32'(bus.stall_o), 32'd0);
      @(negedge clk);
      resetn = 1'b1;
      tick();

      // A fresh divide after the reset runs cleanly
      run_div("post_rst", dv[6]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
